// File: rtl/mem_port_arbiter_if.sv
// Bundles the instruction port, data port and RAM port of mem_port_arbiter.
// The slave modport is the arbiter's view; master is the processor/RAM side.
interface mem_port_arbiter_if;
  logic        iReq_i;
  logic [31:0] iAddr_i;
  logic        iKill_i;
  logic [31:0] iData_o;
  logic        iValid_o;
  logic        iStall_o;

  logic        dReq_i;
  logic        dWe_i;
  logic [31:0] dAddr_i;
  logic [31:0] dWData_i;
  logic [3:0]  dWMask_i;
  logic [31:0] dRData_o;
  logic        dValid_o;
  logic        dStall_o;

  logic [31:0] memAddr_o;
  logic [31:0] memWData_o;
  logic [3:0]  memWMask_o;
  logic        memRe_o;
  logic [31:0] memRData_i;

  modport slave (
    input  iReq_i, iAddr_i, iKill_i,
    output iData_o, iValid_o, iStall_o,
    input  dReq_i, dWe_i, dAddr_i, dWData_i, dWMask_i,
    output dRData_o, dValid_o, dStall_o,
    output memAddr_o, memWData_o, memWMask_o, memRe_o,
    input  memRData_i
  );

  modport master (
    output iReq_i, iAddr_i, iKill_i,
    input  iData_o, iValid_o, iStall_o,
    output dReq_i, dWe_i, dAddr_i, dWData_i, dWMask_i,
    input  dRData_o, dValid_o, dStall_o,
    input  memAddr_o, memWData_o, memWMask_o, memRe_o,
    output memRData_i
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and data access onto one 1-cycle-latency RAM port.
// Optional starvation guard for fetch is built when MEM_ARB_STARVE_GUARD_EN is defined.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic               clk_i,
  input logic               reset_i,
  mem_port_arbiter_if.slave bus
);

  // State | meaning
  // NONE  | no RAM response returns this cycle
  // INST  | instruction read data returns this cycle
  // DREAD | data read data returns this cycle
  // DWRITE| data write acknowledge returns this cycle
  typedef enum logic [1:0] {
    RESP_NONE   = 2'd0,
    RESP_INST   = 2'd1,
    RESP_DREAD  = 2'd2,
    RESP_DWRITE = 2'd3
  } resp_e;

  resp_e resp_q, resp_d;
  logic  gnt_inst, gnt_data;
  logic  force_inst;

  always_comb begin
    gnt_inst = 1'b0;
    gnt_data = 1'b0;
    if (!reset_i) begin
      if (bus.iReq_i && bus.dReq_i) begin
        if (force_inst) gnt_inst = 1'b1;
        else            gnt_data = 1'b1;
      end else if (bus.iReq_i) begin
        gnt_inst = 1'b1;
      end else if (bus.dReq_i) begin
        gnt_data = 1'b1;
      end
    end
  end

  always_comb begin
    bus.memAddr_o  = bus.iAddr_i;
    bus.memWData_o = bus.dWData_i;
    bus.memWMask_o = 4'h0;
    bus.memRe_o    = 1'b0;
    resp_d         = RESP_NONE;
    if (gnt_inst) begin
      bus.memRe_o = 1'b1;
      resp_d      = RESP_INST;
    end else if (gnt_data) begin
      bus.memAddr_o = bus.dAddr_i;
      if (bus.dWe_i) begin
        bus.memWMask_o = bus.dWMask_i;
        resp_d         = RESP_DWRITE;
      end else begin
        bus.memRe_o = 1'b1;
        resp_d      = RESP_DREAD;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) resp_q <= RESP_NONE;
    else         resp_q <= resp_d;
  end

  // Outputs are also masked during reset so a pending response is dropped at once.
  always_comb begin
    bus.iValid_o = 1'b0;
    bus.iData_o  = 32'h0;
    bus.dValid_o = 1'b0;
    bus.dRData_o = 32'h0;
    if (!reset_i) begin
      case (resp_q)
        RESP_INST: begin
          bus.iValid_o = ~bus.iKill_i;
          bus.iData_o  = bus.memRData_i;
        end
        RESP_DREAD: begin
          bus.dValid_o = 1'b1;
          bus.dRData_o = bus.memRData_i;
        end
        RESP_DWRITE: bus.dValid_o = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.iStall_o = bus.iReq_i & ~gnt_inst;
  assign bus.dStall_o = bus.dReq_i & ~gnt_data;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_q, starve_d;
  logic       same_word_wr;

  always_comb begin
    starve_d = starve_q;
    if (!bus.iReq_i || gnt_inst) starve_d = 4'h0;
    else if (gnt_data && starve_q != LIMIT) starve_d = starve_q + 4'h1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) starve_q <= 4'h0;
    else         starve_q <= starve_d;
  end

  // A write to the word being fetched must land first so the fetch sees new data.
  assign same_word_wr = bus.dWe_i && (bus.dAddr_i[31:2] == bus.iAddr_i[31:2]);
  assign force_inst   = (starve_q == LIMIT) && !same_word_wr;
`else
  logic unused_limit;
  assign unused_limit = |4'(STARVE_LIMIT);
  assign force_inst   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural 1-cycle-latency RAM.
// Expected grant pattern under contention follows MEM_ARB_STARVE_GUARD_EN.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus();
  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (.clk_i(clk), .reset_i(reset), .bus(bus));

  int nvec = 0;
  int nerr = 0;

  logic [31:0] ram [0:4095];
  always @(posedge clk) begin
    if (reset) begin
      ram[12'h040] <= 32'h00000013;
      ram[12'h041] <= 32'h00000093;
      ram[12'h042] <= 32'h00000113;
      ram[12'h010] <= 32'h11111111;
      ram[12'h800] <= 32'hCAFE0001;
    end else begin
      if (bus.memRe_o) bus.memRData_i <= ram[bus.memAddr_o[13:2]];
      for (int b = 0; b < 4; b++)
        if (bus.memWMask_o[b]) ram[bus.memAddr_o[13:2]][8*b +: 8] <= bus.memWData_o[8*b +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] exp_inst;
    bus.iReq_i = 1'b1; bus.iAddr_i = 32'h100; bus.iKill_i = 1'b0;
    bus.dReq_i = 1'b0; bus.dWe_i = 1'b0; bus.dAddr_i = 32'h0;
    bus.dWData_i = 32'h0; bus.dWMask_i = 4'h0;

    // Reset: requests ignored, outputs at reset values
    nxt;
    smp;
    chk("rst_memRe", 32'(bus.memRe_o), 32'd0);
    chk("rst_wmask", 32'(bus.memWMask_o), 32'd0);
    chk("rst_iValid", 32'(bus.iValid_o), 32'd0);
    chk("rst_dValid", 32'(bus.dValid_o), 32'd0);
    chk("rst_iData", bus.iData_o, 32'h0);
    chk("rst_dRData", bus.dRData_o, 32'h0);
    nxt;
    reset = 1'b0;

    // Lone fetch
    smp;
    chk("if_memRe", 32'(bus.memRe_o), 32'd1);
    chk("if_addr", bus.memAddr_o, 32'h100);
    chk("if_istall", 32'(bus.iStall_o), 32'd0);
    chk("if_noval", 32'(bus.iValid_o), 32'd0);
    nxt;
    bus.iReq_i = 1'b0;
    smp;
    chk("if_ivalid", 32'(bus.iValid_o), 32'd1);
    chk("if_idata", bus.iData_o, 32'h00000013);
    chk("if_istall2", 32'(bus.iStall_o), 32'd0);
    nxt;

    // Simple contention: data first, then fetch
    bus.iReq_i = 1'b1; bus.iAddr_i = 32'h104;
    bus.dReq_i = 1'b1; bus.dWe_i = 1'b0; bus.dAddr_i = 32'h2000;
    smp;
    chk("ct_addr", bus.memAddr_o, 32'h2000);
    chk("ct_istall", 32'(bus.iStall_o), 32'd1);
    chk("ct_dstall", 32'(bus.dStall_o), 32'd0);
    nxt;
    bus.dReq_i = 1'b0;
    smp;
    chk("ct_dvalid", 32'(bus.dValid_o), 32'd1);
    chk("ct_drdata", bus.dRData_o, 32'hCAFE0001);
    chk("ct_addr2", bus.memAddr_o, 32'h104);
    chk("ct_istall2", 32'(bus.iStall_o), 32'd0);
    nxt;
    bus.iReq_i = 1'b0;
    smp;
    chk("ct_ivalid", 32'(bus.iValid_o), 32'd1);
    chk("ct_idata", bus.iData_o, 32'h00000093);
    chk("ct_dvalid0", 32'(bus.dValid_o), 32'd0);
    nxt;

    // Sustained contention for 6 cycles
`ifdef MEM_ARB_STARVE_GUARD_EN
    exp_inst = 6'b010000;
`else
    exp_inst = 6'b000000;
`endif
    bus.iReq_i = 1'b1; bus.iAddr_i = 32'h108;
    bus.dReq_i = 1'b1; bus.dWe_i = 1'b0; bus.dAddr_i = 32'h2000;
    for (int c = 0; c < 6; c++) begin
      smp;
      chk($sformatf("sv_addr%0d", c), bus.memAddr_o, exp_inst[c] ? 32'h108 : 32'h2000);
      chk($sformatf("sv_istall%0d", c), 32'(bus.iStall_o), exp_inst[c] ? 32'd0 : 32'd1);
      nxt;
    end
    bus.iReq_i = 1'b0; bus.dReq_i = 1'b0;
    smp;
    nxt;

    // Kill drops only the response returning in its own cycle
    bus.iReq_i = 1'b1; bus.iAddr_i = 32'h100;
    smp;
    chk("kl_addr", bus.memAddr_o, 32'h100);
    nxt;
    bus.iKill_i = 1'b1; bus.iAddr_i = 32'h104;
    smp;
    chk("kl_ivalid0", 32'(bus.iValid_o), 32'd0);
    chk("kl_memRe", 32'(bus.memRe_o), 32'd1);
    chk("kl_addr2", bus.memAddr_o, 32'h104);
    nxt;
    bus.iKill_i = 1'b0; bus.iReq_i = 1'b0;
    smp;
    chk("kl_ivalid1", 32'(bus.iValid_o), 32'd1);
    chk("kl_idata", bus.iData_o, 32'h00000093);
    nxt;

    // Write and fetch to the same address: write wins, fetch sees new data
    bus.iReq_i = 1'b1; bus.iAddr_i = 32'h40;
    bus.dReq_i = 1'b1; bus.dWe_i = 1'b1; bus.dAddr_i = 32'h40;
    bus.dWData_i = 32'hDEADBEEF; bus.dWMask_i = 4'hF;
    smp;
    chk("wr_wmask", 32'(bus.memWMask_o), 32'hF);
    chk("wr_memRe", 32'(bus.memRe_o), 32'd0);
    chk("wr_addr", bus.memAddr_o, 32'h40);
    chk("wr_wdata", bus.memWData_o, 32'hDEADBEEF);
    chk("wr_istall", 32'(bus.iStall_o), 32'd1);
    nxt;
    bus.dReq_i = 1'b0;
    smp;
    chk("wr_ack", 32'(bus.dValid_o), 32'd1);
    chk("wr_ackdata", bus.dRData_o, 32'h0);
    chk("wr_fetchRe", 32'(bus.memRe_o), 32'd1);
    nxt;
    bus.iReq_i = 1'b0;
    smp;
    chk("wr_ivalid", 32'(bus.iValid_o), 32'd1);
    chk("wr_idata", bus.iData_o, 32'hDEADBEEF);
    nxt;

    // Partial byte-mask write then read back
    bus.dReq_i = 1'b1; bus.dWe_i = 1'b1; bus.dAddr_i = 32'h2000;
    bus.dWData_i = 32'h12345678; bus.dWMask_i = 4'h3;
    smp;
    chk("pm_wmask", 32'(bus.memWMask_o), 32'h3);
    nxt;
    bus.dWe_i = 1'b0;
    smp;
    chk("pm_ack", 32'(bus.dValid_o), 32'd1);
    chk("pm_rdRe", 32'(bus.memRe_o), 32'd1);
    nxt;
    bus.dReq_i = 1'b0;
    smp;
    chk("pm_rdata", bus.dRData_o, 32'hCAFE5678);
    chk("pm_dvalid", 32'(bus.dValid_o), 32'd1);
    nxt;

    // Reset with a read response pending
    bus.dReq_i = 1'b1; bus.dAddr_i = 32'h2000;
    smp;
    chk("rp_memRe", 32'(bus.memRe_o), 32'd1);
    nxt;
    reset = 1'b1; bus.dReq_i = 1'b0;
    smp;
    chk("rp_dvalid_rst", 32'(bus.dValid_o), 32'd0);
    nxt;
    reset = 1'b0;
    smp;
    chk("rp_dvalid_after", 32'(bus.dValid_o), 32'd0);
    chk("rp_ivalid_after", 32'(bus.iValid_o), 32'd0);
    nxt;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
